// File: rtl/engine_scheduler_pkg.sv
// Shared constants, FSM state types and the raster-advance helper for the engine scheduler.
package engine_scheduler_pkg;

    localparam int unsigned ENG_SCHED_NUM_ENGINES = 4;
    localparam int unsigned ENG_SCHED_COORD_W     = 11;
    localparam int unsigned ENG_SCHED_DEPTH_W     = 10;

    typedef enum logic {
        IssIdle,
        IssStart
    } issue_state_e;

    typedef enum logic {
        OutEmpty,
        OutHold
    } out_state_e;

    typedef struct packed {
        int unsigned x;
        int unsigned y;
    } raster_pos_t;

    // Next pixel in raster order; x wraps into a y increment, y wraps to the top line.
    function automatic raster_pos_t raster_advance(input int unsigned x, input int unsigned y,
                                                   input int unsigned width,
                                                   input int unsigned height);
        raster_pos_t nxt;
        nxt.x = x + 1;
        nxt.y = y;
        if (x >= width - 1) begin
            nxt.x = 0;
            nxt.y = (y >= height - 1) ? 0 : y + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/engine_scheduler_raster_counter.sv
// Raster-order (x, y) position counter with line/frame boundary flags.
module engine_scheduler_raster_counter
    import engine_scheduler_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 960,
    parameter int unsigned SCREEN_HEIGHT = 720,
    parameter int unsigned COORD_W       = ENG_SCHED_COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               first,
    output logic               last_x,
    output logic               last_y
);

    logic [COORD_W-1:0] x_q, y_q, x_d, y_d;
    raster_pos_t        nxt;

    // Step to the next raster position only when advance is asserted.
    always_comb begin
        nxt = raster_advance(32'(x_q), 32'(y_q), SCREEN_WIDTH, SCREEN_HEIGHT);
        x_d = x_q;
        y_d = y_q;
        if (advance) begin
            x_d = COORD_W'(nxt.x);
            y_d = COORD_W'(nxt.y);
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign first  = (x_q == '0) && (y_q == '0);
    assign last_x = (x_q == COORD_W'(SCREEN_WIDTH - 1));
    assign last_y = (y_q == COORD_W'(SCREEN_HEIGHT - 1));

endmodule

// File: rtl/engine_scheduler.sv
// Round-robin issue of raster pixels to shared engines; in-order retirement to a stream.
module engine_scheduler
    import engine_scheduler_pkg::*;
#(
    parameter int unsigned NUM_ENGINES   = ENG_SCHED_NUM_ENGINES,
    parameter int unsigned SCREEN_WIDTH  = 960,
    parameter int unsigned SCREEN_HEIGHT = 720,
    parameter int unsigned COORD_W       = ENG_SCHED_COORD_W,
    parameter int unsigned DEPTH_W       = ENG_SCHED_DEPTH_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    output logic [COORD_W-1:0]             issue_x,
    output logic [COORD_W-1:0]             issue_y,
    output logic [NUM_ENGINES-1:0]         eng_start,
    input  logic [NUM_ENGINES-1:0]         eng_idle,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
    output logic [NUM_ENGINES-1:0]         eng_ack,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DEPTH_W-1:0]             out_depth,
    output logic [COORD_W-1:0]             out_x,
    output logic [COORD_W-1:0]             out_y,
    output logic                           out_sof,
    output logic                           out_eol,
    output logic                           frame_done
);

    localparam int unsigned PtrW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int unsigned CntW = $clog2(NUM_ENGINES + 1);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(NUM_ENGINES - 1)) ? '0 : p + PtrW'(1);
    endfunction

    issue_state_e     iss_state_q, iss_state_d;
    out_state_e       out_state_q, out_state_d;
    logic [PtrW-1:0]  issue_ptr_q, issue_ptr_d, start_ptr_q, start_ptr_d;
    logic [PtrW-1:0]  retire_ptr_q, retire_ptr_d;
    logic [CntW-1:0]  in_flight_q, in_flight_d;
    logic [COORD_W-1:0] issue_x_q, issue_x_d, issue_y_q, issue_y_d;
    logic [COORD_W-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
    logic [DEPTH_W-1:0] out_depth_q, out_depth_d;
    logic             out_sof_q, out_sof_d, out_eol_q, out_eol_d, out_last_q, out_last_d;
    logic [NUM_ENGINES-1:0] eng_ack_q, eng_ack_d;
    logic             frame_done_q, frame_done_d;

    logic             issue_fire, retire_fire;
    logic [COORD_W-1:0] iss_x, iss_y, ret_x, ret_y;
    logic             iss_first, iss_last_x, iss_last_y;
    logic             ret_first, ret_last_x, ret_last_y;
    logic             unused_iss_flags;

    assign out_valid   = (out_state_q == OutHold);
    assign issue_fire  = enable && (in_flight_q < CntW'(NUM_ENGINES)) && eng_idle[issue_ptr_q];
    // The output register can take a new beat when empty or being drained this cycle.
    assign retire_fire = (in_flight_q != '0) && eng_done[retire_ptr_q] &&
                         (!out_valid || out_ready);

    engine_scheduler_raster_counter #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .COORD_W       (COORD_W)
    ) u_issue_cnt (
        .clk     (clk),
        .reset   (reset),
        .advance (issue_fire),
        .x       (iss_x),
        .y       (iss_y),
        .first   (iss_first),
        .last_x  (iss_last_x),
        .last_y  (iss_last_y)
    );

    engine_scheduler_raster_counter #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .COORD_W       (COORD_W)
    ) u_retire_cnt (
        .clk     (clk),
        .reset   (reset),
        .advance (retire_fire),
        .x       (ret_x),
        .y       (ret_y),
        .first   (ret_first),
        .last_x  (ret_last_x),
        .last_y  (ret_last_y)
    );

    assign unused_iss_flags = ^{iss_first, iss_last_x, iss_last_y};

    // Issue side: capture coordinate and target engine, pulse start in the following cycle.
    always_comb begin
        iss_state_d = issue_fire ? IssStart : IssIdle;
        issue_ptr_d = issue_fire ? ptr_inc(issue_ptr_q) : issue_ptr_q;
        start_ptr_d = issue_fire ? issue_ptr_q : start_ptr_q;
        issue_x_d   = issue_fire ? iss_x : issue_x_q;
        issue_y_d   = issue_fire ? iss_y : issue_y_q;
        eng_start   = '0;
        if (iss_state_q == IssStart) begin
            eng_start = NUM_ENGINES'(1) << start_ptr_q;
        end
    end

    // Retire side: output register FSM, engine ack and frame-end detection.
    always_comb begin
        out_state_d  = out_state_q;
        retire_ptr_d = retire_ptr_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_depth_d  = out_depth_q;
        out_sof_d    = out_sof_q;
        out_eol_d    = out_eol_q;
        out_last_d   = out_last_q;
        eng_ack_d    = '0;
        frame_done_d = out_valid && out_ready && out_eol_q && out_last_q;
        unique case (out_state_q)
            OutEmpty: if (retire_fire) out_state_d = OutHold;
            OutHold:  if (!retire_fire && out_ready) out_state_d = OutEmpty;
            default:  out_state_d = OutEmpty;
        endcase
        if (retire_fire) begin
            retire_ptr_d = ptr_inc(retire_ptr_q);
            out_x_d      = ret_x;
            out_y_d      = ret_y;
            out_depth_d  = eng_depth[retire_ptr_q*DEPTH_W +: DEPTH_W];
            out_sof_d    = ret_first;
            out_eol_d    = ret_last_x;
            out_last_d   = ret_last_x && ret_last_y;
            eng_ack_d    = NUM_ENGINES'(1) << retire_ptr_q;
        end
    end

    // Outstanding pixel count; simultaneous issue and retire cancel out.
    always_comb begin
        in_flight_d = in_flight_q;
        unique case ({issue_fire, retire_fire})
            2'b10:   in_flight_d = in_flight_q + CntW'(1);
            2'b01:   in_flight_d = in_flight_q - CntW'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_state_q  <= IssIdle;
            out_state_q  <= OutEmpty;
            issue_ptr_q  <= '0;
            start_ptr_q  <= '0;
            retire_ptr_q <= '0;
            in_flight_q  <= '0;
            issue_x_q    <= '0;
            issue_y_q    <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_depth_q  <= '0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_last_q   <= 1'b0;
            eng_ack_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            iss_state_q  <= iss_state_d;
            out_state_q  <= out_state_d;
            issue_ptr_q  <= issue_ptr_d;
            start_ptr_q  <= start_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            in_flight_q  <= in_flight_d;
            issue_x_q    <= issue_x_d;
            issue_y_q    <= issue_y_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_depth_q  <= out_depth_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_last_q   <= out_last_d;
            eng_ack_q    <= eng_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign issue_x    = issue_x_q;
    assign issue_y    = issue_y_q;
    assign eng_ack    = eng_ack_q;
    assign out_depth  = out_depth_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_sof    = out_sof_q & out_valid;
    assign out_eol    = out_eol_q & out_valid;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_engine_scheduler.sv
// Scoreboard bench for engine_scheduler with behavioural latency-programmable engines.
module tb_engine_scheduler;

    localparam int unsigned NE = 4;
    localparam int unsigned SW = 4;
    localparam int unsigned SH = 2;
    localparam int unsigned CW = 11;
    localparam int unsigned DW = 10;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
    } beat_t;

    typedef struct packed {
        logic [NE-1:0] oh;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } start_t;

    logic clk = 1'b0;
    logic reset, enable, out_ready;
    logic [CW-1:0] issue_x, issue_y, out_x, out_y;
    logic [NE-1:0] eng_start, eng_idle, eng_done, eng_ack;
    logic [NE*DW-1:0] eng_depth;
    logic out_valid, out_sof, out_eol, frame_done;
    logic [DW-1:0] out_depth;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    engine_scheduler #(
        .NUM_ENGINES   (NE),
        .SCREEN_WIDTH  (SW),
        .SCREEN_HEIGHT (SH),
        .COORD_W       (CW),
        .DEPTH_W       (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .issue_x    (issue_x),
        .issue_y    (issue_y),
        .eng_start  (eng_start),
        .eng_idle   (eng_idle),
        .eng_done   (eng_done),
        .eng_depth  (eng_depth),
        .eng_ack    (eng_ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_depth  (out_depth),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .frame_done (frame_done)
    );

    // Engine model: done rises lat_cfg[k]+1 cycles after start, cleared by ack.
    int            lat_cfg   [NE];
    logic [DW-1:0] depth_cfg [NE];
    logic [NE-1:0] m_busy, m_done;
    logic [DW-1:0] m_dep [NE];
    int            m_cnt [NE];

    always @(posedge clk) begin
        for (int k = 0; k < NE; k++) begin
            if (reset) begin
                m_busy[k] <= 1'b0;
                m_done[k] <= 1'b0;
                m_cnt[k]  <= 0;
                m_dep[k]  <= '0;
            end else if (eng_ack[k]) begin
                m_busy[k] <= 1'b0;
                m_done[k] <= 1'b0;
            end else if (eng_start[k]) begin
                m_busy[k] <= 1'b1;
                m_cnt[k]  <= lat_cfg[k];
                m_dep[k]  <= depth_cfg[k];
            end else if (m_busy[k] && !m_done[k]) begin
                if (m_cnt[k] == 0) m_done[k] <= 1'b1;
                else m_cnt[k] <= m_cnt[k] - 1;
            end
        end
    end

    assign eng_idle = ~m_busy;
    assign eng_done = m_done;

    always_comb begin
        eng_depth = '0;
        for (int k = 0; k < NE; k++) eng_depth[k*DW +: DW] = m_dep[k];
    end

    // Recorder: expected beats pushed per start from an independent raster model,
    // observed beats pushed per output handshake.
    beat_t  exp_q[$];
    beat_t  obs_q[$];
    start_t start_q[$];
    int     obs_cyc[$];
    int     st_cyc[$];
    int     fd_cyc[$];
    int     cyc = 0;
    int     ack_cnt = 0;
    int     mx = 0, my = 0, mptr = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            exp_q.delete();
            obs_q.delete();
            start_q.delete();
            obs_cyc.delete();
            st_cyc.delete();
            fd_cyc.delete();
            ack_cnt <= 0;
            mx      <= 0;
            my      <= 0;
            mptr    <= 0;
        end else begin
            if (eng_start != '0) begin
                start_q.push_back('{eng_start, issue_x, issue_y});
                st_cyc.push_back(cyc);
                exp_q.push_back('{CW'(mx), CW'(my), depth_cfg[mptr],
                                  (mx == 0) && (my == 0), mx == SW - 1});
                mx   <= (mx == SW - 1) ? 0 : mx + 1;
                my   <= (mx == SW - 1) ? ((my == SH - 1) ? 0 : my + 1) : my;
                mptr <= (mptr + 1) % NE;
            end
            if (out_valid && out_ready) begin
                obs_q.push_back('{out_x, out_y, out_depth, out_sof, out_eol});
                obs_cyc.push_back(cyc);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            ack_cnt <= ack_cnt + $countones(eng_ack);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b1;
        tick(2);
        reset     = 1'b0;
    endtask

    task automatic set_engines(input int l0, input int l1, input int l2, input int l3,
                               input int dbase);
        lat_cfg[0] = l0;
        lat_cfg[1] = l1;
        lat_cfg[2] = l2;
        lat_cfg[3] = l3;
        for (int k = 0; k < NE; k++) depth_cfg[k] = DW'(dbase + k);
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int i = 0; i < budget && obs_q.size() < n; i++) tick(1);
    endtask

    task automatic enable_until_starts(input int n, input int budget);
        enable = 1'b1;
        for (int i = 0; i < budget && start_q.size() < n; i++) tick(1);
        enable = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        at_neg();
        n_checks++;
        if (eng_start !== '0) $display("FAIL reset_start: got %b want 0", eng_start);
        else n_pass++;
        n_checks++;
        if (eng_ack !== '0) $display("FAIL reset_ack: got %b want 0", eng_ack);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if ({issue_x, issue_y} !== '0)
            $display("FAIL reset_issue_xy: got %0d,%0d want 0,0", issue_x, issue_y);
        else n_pass++;
        n_checks++;
        if ({out_x, out_y, out_depth} !== '0)
            $display("FAIL reset_out: got %0d,%0d,%0d want 0", out_x, out_y, out_depth);
        else n_pass++;
        n_checks++;
        if ({out_sof, out_eol, frame_done} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {out_sof, out_eol, frame_done});
        else n_pass++;
        n_checks++;
        if (dut.in_flight_q !== '0) $display("FAIL reset_in_flight: got %0d want 0",
                                             dut.in_flight_q);
        else n_pass++;
    endtask

    task automatic test_issue();
        start_t es;
        do_reset();
        set_engines(20, 20, 20, 20, 5);
        enable = 1'b1;
        tick(16);
        enable = 1'b0;
        at_neg();
        n_checks++;
        if (start_q.size() != 4) $display("FAIL issue_count: got %0d want 4", start_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < start_q.size(); i++) begin
            es.oh = NE'(1) << i;
            es.x  = CW'(i);
            es.y  = '0;
            n_checks++;
            if (start_q[i] !== es) $display("FAIL issue_start%0d: got %h want %h",
                                            i, start_q[i], es);
            else n_pass++;
            n_checks++;
            if (st_cyc[i] - st_cyc[0] != i)
                $display("FAIL issue_cycle%0d: got +%0d want +%0d", i, st_cyc[i] - st_cyc[0], i);
            else n_pass++;
        end
        wait_obs(4, 60);
        n_checks++;
        if (obs_q.size() != 4) $display("FAIL issue_beats: got %0d want 4", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL issue_beat%0d: got %h want %h",
                                                i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (ack_cnt != 4) $display("FAIL issue_acks: got %0d want 4", ack_cnt);
        else n_pass++;
    endtask

    task automatic test_out_of_order();
        logic [DW-1:0] want;
        do_reset();
        set_engines(4, 5, 1, 6, 5);
        enable_until_starts(4, 20);
        wait_obs(4, 80);
        at_neg();
        n_checks++;
        if (obs_q.size() != 4) $display("FAIL ooo_beats: got %0d want 4", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            want = DW'(5 + i);
            n_checks++;
            if (obs_q[i].d !== want || obs_q[i] !== exp_q[i])
                $display("FAIL ooo_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_engines(0, 0, 0, 0, 5);
        out_ready = 1'b0;
        enable_until_starts(4, 20);
        tick(8);
        for (int i = 0; i < 5; i++) begin
            at_neg();
            n_checks++;
            if (out_valid !== 1'b1 || out_depth !== DW'(5))
                $display("FAIL bp_hold%0d: got valid=%b depth=%0d want 1,5", i, out_valid,
                         out_depth);
            else n_pass++;
            tick(1);
        end
        n_checks++;
        if (ack_cnt != 1 || obs_q.size() != 0)
            $display("FAIL bp_one_ack: got acks=%0d beats=%0d want 1,0", ack_cnt, obs_q.size());
        else n_pass++;
        out_ready = 1'b1;
        wait_obs(4, 20);
        at_neg();
        n_checks++;
        if (obs_q.size() != 4) $display("FAIL bp_beats: got %0d want 4", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i] || obs_cyc[i] - obs_cyc[0] != i)
                $display("FAIL bp_stream%0d: got %h at +%0d want %h at +%0d", i, obs_q[i],
                         obs_cyc[i] - obs_cyc[0], exp_q[i], i);
            else n_pass++;
        end
    endtask

    task automatic test_frame();
        do_reset();
        set_engines(2, 0, 3, 1, 0);
        for (int k = 0; k < NE; k++) depth_cfg[k] = DW'($urandom_range(0, 1023));
        enable = 1'b1;
        wait_obs(9, 200);
        enable = 1'b0;
        tick(30);
        at_neg();
        n_checks++;
        if (obs_q.size() < 9) $display("FAIL frame_beats: got %0d want >=9", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL frame_beat%0d: got %h want %h",
                                                i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        if (obs_q.size() >= 9) begin
            n_checks++;
            if (obs_q[8].sof !== 1'b1 || obs_q[8].x !== '0 || obs_q[8].y !== '0)
                $display("FAIL frame_wrap_sof: got %h want x=0 y=0 sof=1", obs_q[8]);
            else n_pass++;
            n_checks++;
            if (fd_cyc.size() != 1 || fd_cyc[0] != obs_cyc[7] + 1)
                $display("FAIL frame_done: got %0d pulses want 1 at handshake+1", fd_cyc.size());
            else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != start_q.size())
            $display("FAIL frame_drain: got %0d beats want %0d", obs_q.size(), start_q.size());
        else n_pass++;
    endtask

    task automatic test_enable();
        start_t es;
        do_reset();
        set_engines(3, 3, 3, 3, 1);
        enable = 1'b1;
        tick(2);
        enable = 1'b0;
        tick(20);
        at_neg();
        n_checks++;
        if (start_q.size() != 2 || obs_q.size() != 2 || ack_cnt != 2)
            $display("FAIL en_drain: got starts=%0d beats=%0d acks=%0d want 2,2,2",
                     start_q.size(), obs_q.size(), ack_cnt);
        else n_pass++;
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL en_beat%0d: got %h want %h",
                                                i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        tick(1);
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(3);
        at_neg();
        es.oh = 4'b0100;
        es.x  = CW'(2);
        es.y  = '0;
        n_checks++;
        if (start_q.size() != 3) $display("FAIL en_resume_count: got %0d want 3",
                                          start_q.size());
        else n_pass++;
        if (start_q.size() >= 3) begin
            n_checks++;
            if (start_q[2] !== es) $display("FAIL en_resume: got %h want %h", start_q[2], es);
            else n_pass++;
        end
        wait_obs(3, 20);
        at_neg();
        n_checks++;
        if (obs_q.size() != 3 || obs_q[obs_q.size()-1] !== exp_q[2])
            $display("FAIL en_resume_beat: got %0d beats want 3 ending %h", obs_q.size(),
                     exp_q[2]);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        start_t es;
        do_reset();
        set_engines(30, 30, 30, 30, 9);
        enable = 1'b1;
        tick(3);
        enable = 1'b0;
        tick(4);
        n_checks++;
        if (dut.in_flight_q !== 3) $display("FAIL mid_in_flight: got %0d want 3",
                                            dut.in_flight_q);
        else n_pass++;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        at_neg();
        n_checks++;
        if (eng_start !== '0 || eng_ack !== '0 || out_valid !== 1'b0)
            $display("FAIL mid_outputs: got start=%b ack=%b valid=%b want 0", eng_start,
                     eng_ack, out_valid);
        else n_pass++;
        n_checks++;
        if ({issue_x, issue_y} !== '0 || dut.in_flight_q !== '0)
            $display("FAIL mid_state: got x=%0d y=%0d inflight=%0d want 0", issue_x, issue_y,
                     dut.in_flight_q);
        else n_pass++;
        tick(1);
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(2);
        at_neg();
        es.oh = 4'b0001;
        es.x  = '0;
        es.y  = '0;
        n_checks++;
        if (start_q.size() != 1 || start_q[0] !== es)
            $display("FAIL mid_restart: got %0d starts first %h want 1 of %h", start_q.size(),
                     (start_q.size() > 0) ? start_q[0] : '0, es);
        else n_pass++;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < NE; k++) begin
            lat_cfg[k]   = 0;
            depth_cfg[k] = '0;
        end
        test_reset();
        test_issue();
        test_out_of_order();
        test_backpressure();
        test_frame();
        test_enable();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
